// File: rtl/fp_freq_meter.sv
// Gated frequency/period meter: counts sig_in rising edges over a fixed clk_in gate window
// and reports Hz plus shortest/longest rise-to-rise interval (IDLE -> GATE -> REPORT).
module fp_freq_meter #(
  parameter int unsigned INPUT_CLK_HZ = 100000000,
  parameter int unsigned GATE_MS      = 1,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned PER_W        = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             enable_in,
  input  logic             sig_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] edge_count,
  output logic [CNT_W-1:0] freq_hz,
  output logic [PER_W-1:0] period_min,
  output logic [PER_W-1:0] period_max,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned GATE_CYCLES = INPUT_CLK_HZ / 1000 * GATE_MS;
  localparam int unsigned SCALE       = 1000 / GATE_MS;
  localparam int unsigned GC_W        = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned SC_W        = $clog2(SCALE + 1);
  localparam int unsigned PR_W        = CNT_W + SC_W;

  if ((1000 % GATE_MS) != 0) begin : g_gate_ms_chk
    $error("fp_freq_meter: GATE_MS must divide 1000");
  end
  if (GATE_CYCLES < 2) begin : g_gate_len_chk
    $error("fp_freq_meter: gate window must be at least 2 clk_in cycles");
  end

  typedef enum logic [1:0] {IDLE, GATE, REPORT} state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [GC_W-1:0]   gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
  logic              seen_q, seen_d;
  logic [PER_W-1:0]  min_q, min_d, max_q, max_d;
  logic              ovf_q, ovf_d;
  logic              meas_valid_q, meas_valid_d;
  logic [CNT_W-1:0]  edge_count_q, edge_count_d, freq_q, freq_d;
  logic [PER_W-1:0]  pmin_q, pmin_d, pmax_q, pmax_d;
  logic              overflow_q, overflow_d, busy_q, busy_d;
  logic              rise, start_gate, mult_sat;
  logic [PR_W-1:0]   prod;

  assign rise = sync2_q & ~sync3_q;

  always_comb begin
    state_d      = state_q;
    sync1_d      = sig_in;
    sync2_d      = sync1_q;
    sync3_d      = sync2_q;
    gate_cnt_d   = gate_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    per_cnt_d    = per_cnt_q;
    seen_d       = seen_q;
    min_d        = min_q;
    max_d        = max_q;
    ovf_d        = ovf_q;
    meas_valid_d = 1'b0;
    edge_count_d = edge_count_q;
    freq_d       = freq_q;
    pmin_d       = pmin_q;
    pmax_d       = pmax_q;
    overflow_d   = overflow_q;
    start_gate   = 1'b0;
    prod         = '0;
    mult_sat     = 1'b0;

    case (state_q)
      IDLE: start_gate = enable_in;
      GATE: begin
        if (!enable_in) begin
          state_d = IDLE;
        end else begin
          gate_cnt_d = gate_cnt_q + GC_W'(1);
          if (rise) begin
            if (edge_cnt_q == '1) ovf_d = 1'b1;
            else                  edge_cnt_d = edge_cnt_q + CNT_W'(1);
            per_cnt_d = PER_W'(1);
            seen_d    = 1'b1;
            if (seen_q) begin
              if (per_cnt_q < min_q) min_d = per_cnt_q;
              if (per_cnt_q > max_q) max_d = per_cnt_q;
            end
          end else if (per_cnt_q == '1) begin
            ovf_d = 1'b1;
          end else begin
            per_cnt_d = per_cnt_q + PER_W'(1);
          end
          if (gate_cnt_q == GC_W'(GATE_CYCLES - 1)) state_d = REPORT;
        end
      end
      REPORT: begin
        if (enable_in) start_gate = 1'b1;
        else           state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (start_gate) begin
      state_d    = GATE;
      gate_cnt_d = '0;
      edge_cnt_d = '0;
      per_cnt_d  = '0;
      seen_d     = 1'b0;
      min_d      = '1;
      max_d      = '0;
      ovf_d      = 1'b0;
    end

    // Results are registered on the edge entering REPORT so they appear with meas_valid.
    if (state_d == REPORT) begin
      prod         = PR_W'(edge_cnt_d) * PR_W'(SCALE);
      mult_sat     = |prod[PR_W-1:CNT_W];
      meas_valid_d = 1'b1;
      edge_count_d = edge_cnt_d;
      freq_d       = mult_sat ? '1 : prod[CNT_W-1:0];
      overflow_d   = ovf_d | mult_sat;
      if (edge_cnt_d >= CNT_W'(2)) begin
        pmin_d = min_d;
        pmax_d = max_d;
      end else begin
        pmin_d = '0;
        pmax_d = '0;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      per_cnt_q    <= '0;
      seen_q       <= 1'b0;
      min_q        <= '0;
      max_q        <= '0;
      ovf_q        <= 1'b0;
      meas_valid_q <= 1'b0;
      edge_count_q <= '0;
      freq_q       <= '0;
      pmin_q       <= '0;
      pmax_q       <= '0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync3_q      <= sync3_d;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      per_cnt_q    <= per_cnt_d;
      seen_q       <= seen_d;
      min_q        <= min_d;
      max_q        <= max_d;
      ovf_q        <= ovf_d;
      meas_valid_q <= meas_valid_d;
      edge_count_q <= edge_count_d;
      freq_q       <= freq_d;
      pmin_q       <= pmin_d;
      pmax_q       <= pmax_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
    end
  end

  assign meas_valid = meas_valid_q;
  assign edge_count = edge_count_q;
  assign freq_hz    = freq_q;
  assign period_min = pmin_q;
  assign period_max = pmax_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fp_freq_meter.sv
// Bench for fp_freq_meter: an edge-log model predicts each gate's report, results are
// queued when the gate's stimulus is complete and compared when meas_valid fires.
module tb_fp_freq_meter;

  localparam int GA = 100;   // gate cycles of dut_a (100 kHz clock, 1 ms)
  localparam int GB = 1000;  // gate cycles of dut_b (1 MHz clock, 1 ms)

  typedef struct packed {
    logic [31:0] cnt;
    logic [31:0] freq;
    logic [15:0] pmin;
    logic [15:0] pmax;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en_a = 1'b0, sig_a = 1'b0, en_b = 1'b0, sig_b = 1'b0;
  logic        meas_valid_a, overflow_a, busy_a;
  logic [31:0] edge_count_a, freq_hz_a;
  logic [15:0] period_min_a, period_max_a;
  logic        meas_valid_b, overflow_b, busy_b;
  logic [7:0]  edge_count_b, freq_hz_b;
  logic [3:0]  period_min_b, period_max_b;

  int     cyc = 0;
  int     total = 0;
  int     bad = 0;
  int     mode_a = 0, per_a = 1, mode_b = 0, per_b = 1;
  longint acc_a = 0;
  logic   na, nb;
  int     log_a[$], log_b[$];
  res_t   sb_a[$], sb_b[$];
  int     sbt_a[$], sbt_b[$];
  res_t   last_a = '0;

  fp_freq_meter #(.INPUT_CLK_HZ(100000), .GATE_MS(1), .CNT_W(32), .PER_W(16)) dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .enable_in(en_a), .sig_in(sig_a),
    .meas_valid(meas_valid_a), .edge_count(edge_count_a), .freq_hz(freq_hz_a),
    .period_min(period_min_a), .period_max(period_max_a), .overflow(overflow_a), .busy(busy_a));

  fp_freq_meter #(.INPUT_CLK_HZ(1000000), .GATE_MS(1), .CNT_W(8), .PER_W(4)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .enable_in(en_b), .sig_in(sig_b),
    .meas_valid(meas_valid_b), .edge_count(edge_count_b), .freq_hz(freq_hz_b),
    .period_min(period_min_b), .period_max(period_max_b), .overflow(overflow_b), .busy(busy_b));

  always #5 clk = ~clk;

  // Stimulus generator: value driven 1 ns after edge cyc; each 0->1 is logged with that cyc.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    case (mode_a)
      1: na = ((cyc % per_a) == 0);
      2: na = ~sig_a;
      3: begin
        acc_a = acc_a + 3579545;
        if (acc_a >= 100000000) begin acc_a = acc_a - 100000000; na = 1'b1; end
        else na = 1'b0;
      end
      default: na = 1'b0;
    endcase
    nb = (mode_b == 1) ? ((cyc % per_b) == 0) : 1'b0;
    if (na && !sig_a) log_a.push_back(cyc);
    if (nb && !sig_b) log_b.push_back(cyc);
    sig_a = na;
    sig_b = nb;
  end

  // A rise driven after edge k is counted at edge k+3; the gate counts at edges w..w+g-1.
  function automatic res_t model(input int w, input int g, input int cw, input int pw,
                                 input int rl[$]);
    res_t   r;
    longint cmax, f;
    int     pm, n, ref_e, prev, c, e_last, smp, smin, smax, ncl;
    bit     have_prev, ovf;
    cmax = (longint'(1) << cw) - 1;
    pm = (1 << pw) - 1;
    e_last = w + g - 1;
    n = 0; ovf = 1'b0; ref_e = w; prev = 0; have_prev = 1'b0; smin = pm; smax = 0;
    foreach (rl[i]) begin
      c = rl[i] + 3;
      if (c >= w && c <= e_last) begin
        if (c - 1 - ref_e >= pm) ovf = 1'b1;
        if (have_prev) begin
          smp = (c - prev > pm) ? pm : c - prev;
          if (smp < smin) smin = smp;
          if (smp > smax) smax = smp;
        end
        have_prev = 1'b1; prev = c; ref_e = c; n++;
      end
    end
    if (e_last - ref_e >= pm) ovf = 1'b1;
    if (longint'(n) > cmax) begin ovf = 1'b1; ncl = int'(cmax); end
    else ncl = n;
    f = longint'(ncl) * 1000;
    if (f > cmax) begin f = cmax; ovf = 1'b1; end
    r.cnt  = 32'(ncl);
    r.freq = 32'(f);
    r.pmin = (ncl >= 2) ? 16'(smin) : 16'd0;
    r.pmax = (ncl >= 2) ? 16'(smax) : 16'd0;
    r.ovf  = ovf;
    return r;
  endfunction

  function automatic res_t sample(input bit ch);
    res_t r;
    if (ch) begin
      r.cnt = 32'(edge_count_b); r.freq = 32'(freq_hz_b);
      r.pmin = 16'(period_min_b); r.pmax = 16'(period_max_b); r.ovf = overflow_b;
    end else begin
      r.cnt = edge_count_a; r.freq = freq_hz_a;
      r.pmin = period_min_a; r.pmax = period_max_a; r.ovf = overflow_a;
    end
    return r;
  endfunction

  function automatic string fmt(input res_t r);
    return $sformatf("cnt=%0d freq=%0d pmin=%0d pmax=%0d ovf=%0b",
                     r.cnt, r.freq, r.pmin, r.pmax, r.ovf);
  endfunction

  task automatic start(input bit ch, output int w);
    @(posedge clk); #2;
    if (ch) en_b = 1'b1; else en_a = 1'b1;
    w = cyc + 2;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin @(posedge clk); #2; end
  endtask

  // Once the gate's last countable stimulus is driven, push the predicted report.
  task automatic push_gate(input bit ch, input int wg);
    int g;
    g = ch ? GB : GA;
    wait_cyc(wg + g - 3);
    if (ch) begin sb_b.push_back(model(wg, g, 8, 4, log_b));   sbt_b.push_back(wg + g - 1); end
    else    begin sb_a.push_back(model(wg, g, 32, 16, log_a)); sbt_a.push_back(wg + g - 1); end
  endtask

  task automatic wait_valid(input bit ch, input int limit, output bit got, output int at,
                            output res_t r);
    got = 1'b0; at = -1; r = '0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((ch ? meas_valid_b : meas_valid_a) === 1'b1) begin
        got = 1'b1; at = cyc; r = sample(ch);
        break;
      end
    end
  endtask

  task automatic test_reset();
    res_t obs;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    obs = sample(0);
    total++;
    if (obs !== '0 || meas_valid_a !== 1'b0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL reset_a: got %s valid=%b busy=%b, want all 0", fmt(obs), meas_valid_a, busy_a);
    end
    obs = sample(1);
    total++;
    if (obs !== '0 || meas_valid_b !== 1'b0 || busy_b !== 1'b0) begin
      bad++; $display("FAIL reset_b: got %s valid=%b busy=%b, want all 0", fmt(obs), meas_valid_b, busy_b);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_stuck();
    int w, at, ex_at; bit got; res_t obs, ex;
    mode_a = 0;
    start(0, w);
    for (int g = 0; g < 2; g++) begin
      push_gate(0, w + g * (GA + 1));
      wait_valid(0, GA + 10, got, at, obs);
      ex = sb_a.pop_front(); ex_at = sbt_a.pop_front(); last_a = ex;
      total++;
      if (!got || at != ex_at) begin bad++; $display("FAIL stuck_time g%0d: valid at %0d, want %0d", g, at, ex_at); end
      total++;
      if (obs !== ex) begin bad++; $display("FAIL stuck_result g%0d: got %s want %s", g, fmt(obs), fmt(ex)); end
    end
    en_a = 1'b0;
  endtask

  task automatic test_strobe();
    int w, at, ex_at; bit got; res_t obs, ex;
    mode_a = 1; per_a = 28;
    start(0, w);
    for (int g = 0; g < 2; g++) begin
      push_gate(0, w + g * (GA + 1));
      wait_valid(0, GA + 10, got, at, obs);
      ex = sb_a.pop_front(); ex_at = sbt_a.pop_front(); last_a = ex;
      total++;
      if (!got || at != ex_at) begin bad++; $display("FAIL strobe_time g%0d: valid at %0d, want %0d", g, at, ex_at); end
      total++;
      if (obs !== ex) begin bad++; $display("FAIL strobe_result g%0d: got %s want %s", g, fmt(obs), fmt(ex)); end
      total++;
      if (obs.pmin !== 16'd28 || obs.pmax !== 16'd28 || obs.ovf !== 1'b0) begin
        bad++; $display("FAIL strobe_period g%0d: got %s want pmin=pmax=28 ovf=0", g, fmt(obs));
      end
      if (g == 0) begin
        total++;
        if (busy_a !== 1'b1) begin bad++; $display("FAIL strobe_busy_report: busy=%b want 1", busy_a); end
        @(negedge clk);
        total++;
        if (meas_valid_a !== 1'b0) begin bad++; $display("FAIL strobe_pulse_width: valid=%b want 0", meas_valid_a); end
      end
    end
    en_a = 1'b0;
  endtask

  task automatic test_fractional();
    int w, at, ex_at; bit got; res_t obs, ex;
    acc_a = 0; mode_a = 3;
    start(0, w);
    for (int g = 0; g < 3; g++) begin
      push_gate(0, w + g * (GA + 1));
      wait_valid(0, GA + 10, got, at, obs);
      ex = sb_a.pop_front(); ex_at = sbt_a.pop_front(); last_a = ex;
      total++;
      if (!got || at != ex_at) begin bad++; $display("FAIL frac_time g%0d: valid at %0d, want %0d", g, at, ex_at); end
      total++;
      if (obs !== ex) begin bad++; $display("FAIL frac_result g%0d: got %s want %s", g, fmt(obs), fmt(ex)); end
    end
    en_a = 1'b0;
  endtask

  task automatic test_toggle();
    int w, at, ex_at; bit got; res_t obs, ex;
    mode_a = 2;
    start(0, w);
    for (int g = 0; g < 2; g++) begin
      push_gate(0, w + g * (GA + 1));
      wait_valid(0, GA + 10, got, at, obs);
      ex = sb_a.pop_front(); ex_at = sbt_a.pop_front(); last_a = ex;
      total++;
      if (!got || at != ex_at) begin bad++; $display("FAIL toggle_time g%0d: valid at %0d, want %0d", g, at, ex_at); end
      total++;
      if (obs !== ex) begin bad++; $display("FAIL toggle_result g%0d: got %s want %s", g, fmt(obs), fmt(ex)); end
      total++;
      if (obs.pmin !== 16'd2 || obs.pmax !== 16'd2 || obs.cnt < 32'd49 || obs.cnt > 32'd51) begin
        bad++; $display("FAIL toggle_limits g%0d: got %s want cnt 49..51 pmin=pmax=2", g, fmt(obs));
      end
    end
    en_a = 1'b0;
    mode_a = 1; per_a = 13;
  endtask

  task automatic test_abort();
    int w, at, ex_at, seen; bit got; res_t obs, ex;
    start(0, w);
    wait_cyc(w + 49);
    total++;
    if (busy_a !== 1'b1) begin bad++; $display("FAIL abort_busy_before: busy=%b want 1", busy_a); end
    en_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (busy_a !== 1'b0) begin bad++; $display("FAIL abort_busy_after: busy=%b want 0", busy_a); end
    seen = 0;
    for (int i = 0; i < GA + 10; i++) begin
      @(negedge clk);
      if (meas_valid_a === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL abort_no_valid: %0d pulses, want 0", seen); end
    obs = sample(0);
    total++;
    if (obs !== last_a) begin bad++; $display("FAIL abort_hold: got %s want %s", fmt(obs), fmt(last_a)); end

    start(0, w);
    wait_cyc(w + 30);
    rst_n = 1'b0;
    #1;
    obs = sample(0);
    total++;
    if (obs !== '0 || meas_valid_a !== 1'b0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL reset_mid_gate: got %s valid=%b busy=%b, want all 0", fmt(obs), meas_valid_a, busy_a);
    end
    en_a = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    start(0, w);
    push_gate(0, w);
    wait_valid(0, GA + 10, got, at, obs);
    ex = sb_a.pop_front(); ex_at = sbt_a.pop_front(); last_a = ex;
    total++;
    if (!got || at != ex_at) begin bad++; $display("FAIL reset_regate_time: valid at %0d, want %0d", at, ex_at); end
    total++;
    if (obs !== ex) begin bad++; $display("FAIL reset_regate_result: got %s want %s", fmt(obs), fmt(ex)); end
    en_a = 1'b0;
  endtask

  task automatic test_saturation();
    int w, at, ex_at; bit got; res_t obs, ex;
    for (int k = 0; k < 2; k++) begin
      mode_b = 1; per_b = (k == 0) ? 20 : 2;
      start(1, w);
      push_gate(1, w);
      wait_valid(1, GB + 10, got, at, obs);
      ex = sb_b.pop_front(); ex_at = sbt_b.pop_front();
      total++;
      if (!got || at != ex_at) begin bad++; $display("FAIL sat_time p%0d: valid at %0d, want %0d", per_b, at, ex_at); end
      total++;
      if (obs !== ex) begin bad++; $display("FAIL sat_result p%0d: got %s want %s", per_b, fmt(obs), fmt(ex)); end
      total++;
      if (k == 0 && (obs.pmax !== 16'd15 || obs.ovf !== 1'b1)) begin
        bad++; $display("FAIL sat_period: got %s want pmax=15 ovf=1", fmt(obs));
      end else if (k == 1 && (obs.cnt !== 32'd255 || obs.freq !== 32'd255 || obs.ovf !== 1'b1)) begin
        bad++; $display("FAIL sat_count: got %s want cnt=255 freq=255 ovf=1", fmt(obs));
      end
      en_b = 1'b0;
    end
    mode_b = 0;
  endtask

  initial begin
    test_reset();
    test_stuck();
    test_strobe();
    test_fractional();
    test_toggle();
    test_abort();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
